// File: rtl/mc_bridge.sv
// Synchronous front end for the MCU parallel memory-controller bus: synchronizes the
// asynchronous strobes and issues single-cycle write/read strobes to the register space.
module mc_bridge #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADD_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mc_ce,
  input  logic                  mc_oe,
  input  logic                  mc_we,
  input  logic [ADD_WIDTH-1:0]  mc_add,
  input  logic [DATA_WIDTH-1:0] mc_din,
  output logic [DATA_WIDTH-1:0] mc_dout,
  output logic                  mc_doe,
  output logic                  wr_stb,
  output logic [ADD_WIDTH-1:0]  wr_add,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_stb,
  output logic [ADD_WIDTH-1:0]  rd_add,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RHOLD} state_t;

  state_t state, state_d;

  // Strobe synchronizers: bit 0 = s1, bit 1 = s2, bit 2 = s3 (history).
  logic [2:0] ce_q, oe_q, we_q;
  // Falls are masked until the synchronizers have seen the pins after reset.
  logic [2:0] arm;

  logic [ADD_WIDTH-1:0]  add_p1, add_p2, hold_add;
  logic [DATA_WIDTH-1:0] din_p1, din_p2, hold_data;

  logic                  wr_stb_d, rd_stb_d, doe_d;
  logic [ADD_WIDTH-1:0]  wr_add_d, rd_add_d;
  logic [DATA_WIDTH-1:0] wr_data_d, dout_d;

  logic ce_s, oe_s, we_s;
  logic we_fall, we_rise, ce_rise, rd_start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ce_q <= '1;
      oe_q <= '1;
      we_q <= '1;
      arm  <= '0;
    end else begin
      ce_q <= {ce_q[1:0], mc_ce};
      oe_q <= {oe_q[1:0], mc_oe};
      we_q <= {we_q[1:0], mc_we};
      arm  <= {arm[1:0], 1'b1};
    end
  end

  // Address/data pipeline aligned with s1/s2; hold keeps the last value seen with we low.
  always_ff @(posedge clock) begin
    add_p1 <= mc_add;
    add_p2 <= add_p1;
    din_p1 <= mc_din;
    din_p2 <= din_p1;
    if (!we_q[1]) begin
      hold_add  <= add_p2;
      hold_data <= din_p2;
    end
  end

  assign ce_s    = ce_q[1];
  assign oe_s    = oe_q[1];
  assign we_s    = we_q[1];
  assign we_fall = arm[2] & we_q[2] & ~we_q[1];
  assign we_rise = ~we_q[2] & we_q[1];
  assign ce_rise = ~ce_q[2] & ce_q[1];
  // Read start is judged one stage early so rd_stb leaves a register in the fall-detect cycle.
  assign rd_start = arm[1] & oe_q[1] & ~oe_q[0] & ~ce_q[0] & we_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_stb  <= 1'b0;
      wr_add  <= '0;
      wr_data <= '0;
      rd_stb  <= 1'b0;
      rd_add  <= '0;
      mc_dout <= '0;
      mc_doe  <= 1'b0;
    end else begin
      state   <= state_d;
      wr_stb  <= wr_stb_d;
      wr_add  <= wr_add_d;
      wr_data <= wr_data_d;
      rd_stb  <= rd_stb_d;
      rd_add  <= rd_add_d;
      mc_dout <= dout_d;
      mc_doe  <= doe_d;
    end
  end

  always_comb begin
    state_d   = state;
    wr_stb_d  = 1'b0;
    wr_add_d  = wr_add;
    wr_data_d = wr_data;
    rd_stb_d  = 1'b0;
    rd_add_d  = rd_add;
    dout_d    = mc_dout;
    doe_d     = mc_doe;
    case (state)
      IDLE: begin
        if (!ce_s && we_fall) begin
          state_d = WRITE;
        end else if (rd_start) begin
          state_d  = READ;
          rd_stb_d = 1'b1;
          rd_add_d = add_p2;
        end
      end
      WRITE: begin
        if (we_rise && (!ce_s || ce_rise)) begin
          wr_stb_d  = 1'b1;
          wr_add_d  = hold_add;
          wr_data_d = hold_data;
          state_d   = IDLE;
        end else if (ce_s) begin
          state_d = IDLE;
        end
      end
      READ: state_d = RHOLD;
      RHOLD: begin
        // mc_doe low on entry marks the first RHOLD cycle, where rd_data is valid.
        if (oe_s || ce_s || !we_s) begin
          doe_d   = 1'b0;
          state_d = IDLE;
        end else if (!mc_doe) begin
          dout_d = rd_data;
          doe_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_bridge.sv
// Scoreboard bench for mc_bridge: stimulus tasks push expected strobes and data-pin
// windows derived from the bus timing rules; a negedge monitor checks the DUT against them.
module tb_mc_bridge;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 6;

  logic          clock, reset, mc_ce, mc_oe, mc_we;
  logic [AW-1:0] mc_add;
  logic [DW-1:0] mc_din, mc_dout, wr_data, rd_data_v;
  logic          mc_doe, wr_stb, rd_stb;
  logic [AW-1:0] wr_add, rd_add;

  mc_bridge #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_din(mc_din), .mc_dout(mc_dout), .mc_doe(mc_doe),
    .wr_stb(wr_stb), .wr_add(wr_add), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_add(rd_add), .rd_data(rd_data_v)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit            is_rd;
    int            at;
    logic [AW-1:0] add;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           q[$];
  bit            doe_win[int];
  logic [DW-1:0] dout_exp[int];
  int            total = 0;
  int            bad = 0;

  function automatic ev_t mk(input bit is_rd, input int at, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    ev_t e;
    e.is_rd = is_rd;
    e.at    = at;
    e.add   = a;
    e.data  = d;
    return e;
  endfunction

  task automatic chk_strobe(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected at cycle %0d add=%h data=%h (none required)",
               is_rd ? "rd_stb" : "wr_stb", cyc, a, d);
    end else if (q[0].is_rd != is_rd || q[0].at != cyc || q[0].add !== a ||
                 (!is_rd && q[0].data !== d)) begin
      bad++;
      $display("FAIL %s got cycle=%0d add=%h data=%h, required rd=%0d cycle=%0d add=%h data=%h",
               is_rd ? "rd_stb" : "wr_stb", cyc, a, d, q[0].is_rd, q[0].at, q[0].add, q[0].data);
      if (q[0].at == cyc) q.delete(0);
    end else begin
      q.delete(0);
    end
  endtask

  // Monitor: strobes against the scoreboard, data pins against the expected windows.
  always @(negedge clock) begin
    bit exp_doe;
    while (q.size() != 0 && q[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL strobe_missing rd=%0d required at cycle %0d, now %0d", q[0].is_rd, q[0].at, cyc);
      q.delete(0);
    end
    if (wr_stb) chk_strobe(1'b0, wr_add, wr_data);
    if (rd_stb) chk_strobe(1'b1, rd_add, '0);
    exp_doe = (doe_win.exists(cyc) != 0);
    total++;
    if (mc_doe !== exp_doe) begin
      bad++;
      $display("FAIL mc_doe at cycle %0d got %b required %b", cyc, mc_doe, exp_doe);
    end
    if (exp_doe) begin
      total++;
      if (mc_dout !== dout_exp[cyc]) begin
        bad++;
        $display("FAIL mc_dout at cycle %0d got %h required %h", cyc, mc_dout, dout_exp[cyc]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mc_doe"}, 32'(mc_doe), 32'd0);
    chk({tag, "_mc_dout"}, 32'(mc_dout), 32'd0);
    chk({tag, "_wr_stb"}, 32'(wr_stb), 32'd0);
    chk({tag, "_wr_add"}, 32'(wr_add), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_rd_stb"}, 32'(rd_stb), 32'd0);
    chk({tag, "_rd_add"}, 32'(rd_add), 32'd0);
  endtask

  // Write: wr_stb appears 3 clocks after mc_we returns high.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int len,
                          input int gap);
    int c;
    c = cyc;
    q.push_back(mk(1'b0, c + len + 3, a, d));
    mc_add = a;
    mc_din = d;
    mc_we  = 1'b0;
    tick(len);
    mc_we = 1'b1;
    tick(gap);
  endtask

  // Read: rd_stb 2 clocks after mc_oe falls, pins driven from 4 clocks after the fall
  // until 3 clocks after the rise.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int len,
                         input int gap);
    int c;
    mc_add = a;
    tick(3);
    c = cyc;
    rd_data_v = d;
    q.push_back(mk(1'b1, c + 2, a, '0));
    for (int k = c + 4; k <= c + len + 2; k++) begin
      doe_win[k]  = 1'b1;
      dout_exp[k] = d;
    end
    mc_oe = 1'b0;
    tick(len);
    mc_oe = 1'b1;
    tick(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b0;
    mc_ce = 1'b1;
    mc_oe = 1'b1;
    mc_we = 1'b1;
    mc_add = '0;
    mc_din = '0;
    rd_data_v = '0;
    #1 reset = 1'b1;
    #1 chk_reset_values("reset");
    tick(3);
    reset = 1'b0;
    mc_ce = 1'b0;
    tick(5);

    do_write(6'h00, 16'h00A5, 4, 5);
    do_read(6'h19, 16'hBEEF, 8, 5);

    // Aborted write: mc_ce rises 2 clocks before mc_we does.
    mc_add = 6'h0C;
    mc_din = 16'hDEAD;
    mc_we = 1'b0;
    tick(3);
    mc_ce = 1'b1;
    tick(2);
    mc_we = 1'b1;
    tick(3);
    mc_ce = 1'b0;
    tick(5);
    do_write(6'h0D, 16'h0BAD, 3, 4);

    // Simultaneous we/oe: the write wins, no read.
    c = cyc;
    q.push_back(mk(1'b0, c + 7, 6'h05, 16'h1234));
    mc_add = 6'h05;
    mc_din = 16'h1234;
    mc_we = 1'b0;
    mc_oe = 1'b0;
    tick(4);
    mc_we = 1'b1;
    mc_oe = 1'b1;
    tick(5);

    // Reset in the middle of a read while the pins are driven.
    mc_add = 6'h2A;
    tick(3);
    c = cyc;
    rd_data_v = 16'hC0DE;
    q.push_back(mk(1'b1, c + 2, 6'h2A, '0));
    for (int k = c + 4; k <= c + 6; k++) begin
      doe_win[k]  = 1'b1;
      dout_exp[k] = 16'hC0DE;
    end
    mc_oe = 1'b0;
    tick(6);
    #2 reset = 1'b1;
    #1 chk_reset_values("midread");
    tick(2);
    reset = 1'b0;
    tick(6);
    mc_oe = 1'b1;
    tick(5);

    do_write(6'h01, 16'h1111, 4, 3);
    do_write(6'h02, 16'h2222, 4, 3);
    do_write(6'h03, 16'h3333, 4, 5);

    // Write strobe while mc_ce is high is ignored.
    mc_ce = 1'b1;
    tick(4);
    mc_add = 6'h3F;
    mc_din = 16'hFFFF;
    mc_we = 1'b0;
    tick(4);
    mc_we = 1'b1;
    tick(4);
    mc_ce = 1'b0;
    tick(4);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(AW'($urandom), DW'($urandom), int'($urandom_range(6, 3)),
                 int'($urandom_range(6, 3)));
      else
        do_read(AW'($urandom), DW'($urandom), int'($urandom_range(9, 5)),
                int'($urandom_range(7, 4)));
    end

    tick(10);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
